// File: rtl/elevator_call_scheduler.sv
// Four-floor elevator call scheduler: latches hall calls, moves the car and times the door.
// Latency: a registered call is acted on at the next edge; TRAVEL_CYC cycles per floor, DOOR_CYC door dwell.
// Backpressure: none; door_block or a same-floor call holds the door. Optional recall via SCHED_RECALL_EN.
module elevator_call_scheduler #(
   parameter int TRAVEL_CYC = 8,
   parameter int DOOR_CYC   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] call_req,
   input  logic       door_block,
`ifdef SCHED_RECALL_EN
   input  logic       recall,
`endif
   output logic [1:0] floor,
   output logic       moving,
   output logic       dir,
   output logic       door_open,
   output logic [3:0] pend,
   output logic [3:0] lamp_red,
   output logic [3:0] lamp_green
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

   localparam int CMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] TRV_LD  = CW'(TRAVEL_CYC - 1);
   localparam logic [CW-1:0] DOOR_LD = CW'(DOOR_CYC - 1);

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_floor, w_floor_nxt;
   logic          r_dir, w_dir_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]    r_pend, w_pend_nxt;

   logic          w_recall;
   logic [3:0]    w_call;
   logic          w_above, w_below, w_ahead, w_behind;
   logic          w_dir_mv;
   logic [1:0]    w_step_floor;
   logic          w_arrive;
   logic [3:0]    w_serve_oh;

`ifdef SCHED_RECALL_EN
   assign w_recall = recall;
`else
   assign w_recall = 1'b0;
`endif

   // recall masks all hall calls
   assign w_call   = w_recall ? 4'b0000 : call_req;
   assign w_ahead  = r_dir ? w_above : w_below;
   assign w_behind = r_dir ? w_below : w_above;

   // recall always drives the car downwards toward the ground floor
   assign w_dir_mv     = w_recall ? 1'b0 : r_dir;
   assign w_step_floor = w_dir_mv ? (r_floor + 2'd1) : (r_floor - 2'd1);
   assign w_arrive     = w_recall ? (w_step_floor == 2'd0) : r_pend[w_step_floor];

   // which pending calls lie above and below the car
   always_comb begin
      w_above = 1'b0;
      w_below = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(r_floor)) w_above = w_above | r_pend[i];
         if (i < int'(r_floor)) w_below = w_below | r_pend[i];
      end
   end

   // next-state, floor, direction and shared travel/door counter
   always_comb begin
      w_state_nxt = r_state;
      w_floor_nxt = r_floor;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_recall) begin
               if (r_floor == 2'd0) begin
                  w_state_nxt = DOOR;
                  w_cnt_nxt   = DOOR_LD;
               end else begin
                  w_state_nxt = MOVE;
                  w_dir_nxt   = 1'b0;
                  w_cnt_nxt   = TRV_LD;
               end
            end else if (r_pend[r_floor]) begin
               w_state_nxt = DOOR;
               w_cnt_nxt   = DOOR_LD;
            end else if (w_ahead) begin
               w_state_nxt = MOVE;
               w_cnt_nxt   = TRV_LD;
            end else if (w_behind) begin
               w_state_nxt = MOVE;
               w_dir_nxt   = ~r_dir;
               w_cnt_nxt   = TRV_LD;
            end
            // the car can only leave a terminal floor toward the building interior
            if (w_state_nxt == MOVE) begin
               if (r_floor == 2'd0)      w_dir_nxt = 1'b1;
               else if (r_floor == 2'd3) w_dir_nxt = 1'b0;
            end
         end
         MOVE: begin
            if (w_recall && r_floor == 2'd0) begin
               w_state_nxt = DOOR;
               w_cnt_nxt   = DOOR_LD;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
               w_dir_nxt = w_dir_mv;
            end else begin
               w_floor_nxt = w_step_floor;
               w_dir_nxt   = w_dir_mv;
               if (w_arrive) begin
                  w_state_nxt = DOOR;
                  w_cnt_nxt   = DOOR_LD;
               end else if (w_step_floor == 2'd0 || w_step_floor == 2'd3) begin
                  // nothing left in this direction at a terminal floor: stop, never wrap
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = TRV_LD;
               end
            end
         end
         DOOR: begin
            if (w_recall) begin
               if (r_floor == 2'd0) begin
                  w_cnt_nxt = DOOR_LD;
               end else begin
                  w_state_nxt = MOVE;
                  w_dir_nxt   = 1'b0;
                  w_cnt_nxt   = TRV_LD;
               end
            end else if (door_block || call_req[r_floor]) begin
               w_cnt_nxt = DOOR_LD;
            end else if (r_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // latch new calls; a call at the floor whose door is (or is becoming) open is served instead
   always_comb begin
      w_serve_oh = (w_state_nxt == DOOR) ? (4'b0001 << w_floor_nxt) : 4'b0000;
      w_pend_nxt = w_recall ? 4'b0000 : ((r_pend | w_call) & ~w_serve_oh);
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_floor <= 2'd0;
         r_dir   <= 1'b1;
         r_cnt   <= '0;
         r_pend  <= 4'b0000;
      end else begin
         r_state <= w_state_nxt;
         r_floor <= w_floor_nxt;
         r_dir   <= w_dir_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   assign floor      = r_floor;
   assign moving     = (r_state == MOVE);
   assign dir        = r_dir;
   assign door_open  = (r_state == DOOR);
   assign pend       = r_pend;
   assign lamp_red   = r_pend;
   assign lamp_green = (r_state == DOOR) ? (4'b0001 << r_floor) : 4'b0000;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus random traffic against a timer-based car model.
module tb_elevator_call_scheduler;

   localparam int TRAVEL_CYC = 4;
   localparam int DOOR_CYC   = 6;
   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;
   localparam logic [16:0] RST_VEC = {2'd0, 1'b0, 1'b1, 1'b0, 4'b0, 4'b0, 4'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] call_req = 4'b0;
   logic       door_block = 1'b0;
`ifdef SCHED_RECALL_EN
   logic       recall = 1'b0;
`endif
   logic [1:0] floor;
   logic       moving, dir, door_open;
   logic [3:0] pend, lamp_red, lamp_green;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural car model: mode, remaining cycles in the current activity, pending calls
   int         m_floor, m_mode, m_timer;
   bit         m_dir;
   logic [3:0] m_pend;

   elevator_call_scheduler #(.TRAVEL_CYC(TRAVEL_CYC), .DOOR_CYC(DOOR_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .call_req(call_req), .door_block(door_block),
`ifdef SCHED_RECALL_EN
      .recall(recall),
`endif
      .floor(floor), .moving(moving), .dir(dir), .door_open(door_open),
      .pend(pend), .lamp_red(lamp_red), .lamp_green(lamp_green)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] dut_vec();
      return {floor, moving, dir, door_open, pend, lamp_red, lamp_green};
   endfunction

   function automatic logic [16:0] m_vec();
      logic [3:0] g;
      g = (m_mode == M_DOOR) ? (4'b0001 << m_floor) : 4'b0000;
      return {2'(m_floor), (m_mode == M_MOVE), m_dir, (m_mode == M_DOOR), m_pend, m_pend, g};
   endfunction

   function automatic bit any_dir(logic [3:0] p, int fl, bit up);
      bit r = 1'b0;
      for (int i = 0; i < 4; i++)
         if (up ? (i > fl) : (i < fl)) r = r | p[i];
      return r;
   endfunction

   task automatic m_reset();
      m_floor = 0; m_dir = 1'b1; m_mode = M_IDLE; m_timer = 0; m_pend = 4'b0;
   endtask

   task automatic m_step(input logic [3:0] c, input logic b);
      logic [3:0] np;
      int nf, nmode;
      np = m_pend | c;
      nf = m_floor;
      nmode = m_mode;
      if (m_mode == M_IDLE) begin
         if (m_pend[m_floor]) begin
            nmode = M_DOOR; m_timer = DOOR_CYC;
         end else if (any_dir(m_pend, m_floor, m_dir)) begin
            nmode = M_MOVE; m_timer = TRAVEL_CYC;
         end else if (any_dir(m_pend, m_floor, !m_dir)) begin
            m_dir = !m_dir; nmode = M_MOVE; m_timer = TRAVEL_CYC;
         end
         if (nmode == M_MOVE && m_floor == 0) m_dir = 1'b1;
         if (nmode == M_MOVE && m_floor == 3) m_dir = 1'b0;
      end else if (m_mode == M_MOVE) begin
         m_timer--;
         if (m_timer == 0) begin
            nf = m_dir ? m_floor + 1 : m_floor - 1;
            if (m_pend[nf]) begin
               nmode = M_DOOR; m_timer = DOOR_CYC;
            end else if (nf == 0 || nf == 3) begin
               nmode = M_IDLE;
            end else begin
               m_timer = TRAVEL_CYC;
            end
         end
      end else begin
         if (b || c[m_floor]) m_timer = DOOR_CYC;
         else begin
            m_timer--;
            if (m_timer == 0) nmode = M_IDLE;
         end
      end
      if (nmode == M_DOOR) np[nf] = 1'b0;
      m_pend = np;
      m_floor = nf;
      m_mode = nmode;
   endtask

   task automatic tick(input logic [3:0] c, input logic b);
      call_req = c;
      door_block = b;
      @(posedge clk);
      m_step(c, b);
      #1;
   endtask

   task automatic do_reset();
      call_req = 4'b0; door_block = 1'b0; rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dut_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL reset_async got=%b exp=%b", dut_vec(), RST_VEC);
      end
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL reset_hold got=%b exp=%b", dut_vec(), RST_VEC);
      end
      rst_n = 1'b1;
      tick(4'b0100, 1'b0);
      n_cmp++;
      if (pend !== 4'b0100 || moving !== 1'b0) begin
         n_bad++; $display("FAIL reset_first_edge pend=%b moving=%b exp pend=0100 moving=0", pend, moving);
      end
   endtask

   task automatic test_up_travel();
      int door_cnt = 0;
      do_reset();
      tick(4'b1000, 1'b0);
      n_cmp++;
      if (pend !== 4'b1000 || moving !== 1'b0) begin
         n_bad++; $display("FAIL up_latch pend=%b moving=%b exp 1000/0", pend, moving);
      end
      for (int t = 2; t <= 25; t++) begin
         tick(4'b0000, 1'b0);
         if (door_open === 1'b1) door_cnt++;
         if (t == 2) begin
            n_cmp++;
            if (moving !== 1'b1) begin n_bad++; $display("FAIL up_move_start moving=%b exp 1", moving); end
         end
         if (t == 5 || t == 6 || t == 10) begin
            n_cmp++;
            if (int'(floor) != (t == 5 ? 0 : t == 6 ? 1 : 2)) begin
               n_bad++; $display("FAIL up_floor t=%0d got=%0d", t, floor);
            end
         end
         if (t == 14) begin
            n_cmp++;
            if (floor !== 2'd3 || door_open !== 1'b1 || lamp_green !== 4'b1000 || pend !== 4'b0 || moving !== 1'b0) begin
               n_bad++; $display("FAIL up_arrive floor=%0d door=%b green=%b pend=%b exp 3/1/1000/0000", floor, door_open, lamp_green, pend);
            end
         end
      end
      n_cmp++;
      if (door_cnt != DOOR_CYC) begin n_bad++; $display("FAIL up_door_len got=%0d exp=%0d", door_cnt, DOOR_CYC); end
   endtask

   task automatic test_same_floor();
      do_reset();
      tick(4'b0001, 1'b0);
      n_cmp++;
      if (pend !== 4'b0001 || door_open !== 1'b0) begin
         n_bad++; $display("FAIL same_latch pend=%b door=%b exp 0001/0", pend, door_open);
      end
      tick(4'b0001, 1'b0);
      n_cmp++;
      if (door_open !== 1'b1 || pend !== 4'b0 || moving !== 1'b0 || lamp_green !== 4'b0001) begin
         n_bad++; $display("FAIL same_door door=%b pend=%b moving=%b green=%b exp 1/0000/0/0001", door_open, pend, moving, lamp_green);
      end
      repeat (3) begin
         tick(4'b0001, 1'b0);
         n_cmp++;
         if (pend[0] !== 1'b0 || door_open !== 1'b1) begin
            n_bad++; $display("FAIL same_held pend=%b door=%b exp pend0=0 door=1", pend, door_open);
         end
      end
      for (int i = 1; i <= 8; i++) begin
         tick(4'b0000, 1'b0);
         n_cmp++;
         if (door_open !== (i < DOOR_CYC) || moving !== 1'b0) begin
            n_bad++; $display("FAIL same_close i=%0d door=%b moving=%b", i, door_open, moving);
         end
      end
   endtask

   task automatic test_dir_preserve();
      int served[$];
      bit prev_door = 1'b0;
      bit seen3 = 1'b0;
      do_reset();
      tick(4'b1000, 1'b0);
      for (int t = 2; t <= 45; t++) begin
         tick((t == 7) ? 4'b0001 : 4'b0000, 1'b0);
         if (t == 7) begin
            n_cmp++;
            if (pend !== 4'b1001 || moving !== 1'b1 || dir !== 1'b1 || floor !== 2'd1) begin
               n_bad++; $display("FAIL dir_setup pend=%b moving=%b dir=%b floor=%0d", pend, moving, dir, floor);
            end
         end
         if (door_open === 1'b1 && !prev_door) begin
            served.push_back(int'(floor));
            if (floor == 2'd3) seen3 = 1'b1;
         end
         prev_door = (door_open === 1'b1);
         if (seen3 && moving === 1'b1) begin
            n_cmp++;
            if (dir !== 1'b0) begin n_bad++; $display("FAIL dir_after_top dir=%b exp 0", dir); end
         end
      end
      n_cmp++;
      if (served.size() != 2 || served[0] != 3 || served[1] != 0) begin
         n_bad++; $display("FAIL dir_order served=%p exp 3 then 0", served);
      end
   endtask

   task automatic test_door_hold();
      int fall = 0;
      do_reset();
      tick(4'b0001, 1'b0);
      tick(4'b0000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(4'b0000, 1'b1);
         n_cmp++;
         if (door_open !== 1'b1) begin n_bad++; $display("FAIL hold_open i=%0d door=%b", i, door_open); end
      end
      for (int i = 1; i <= 10; i++) begin
         tick(4'b0000, 1'b0);
         if (door_open !== 1'b1 && fall == 0) fall = i;
      end
      n_cmp++;
      if (fall != DOOR_CYC) begin n_bad++; $display("FAIL hold_release got=%0d exp=%0d", fall, DOOR_CYC); end
   endtask

   task automatic test_reset_mid_move();
      do_reset();
      tick(4'b1000, 1'b0);
      repeat (7) tick(4'b0000, 1'b0);
      n_cmp++;
      if (moving !== 1'b1 || floor !== 2'd1 || pend !== 4'b1000) begin
         n_bad++; $display("FAIL midrst_setup moving=%b floor=%0d pend=%b", moving, floor, pend);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dut_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL midrst_async got=%b exp=%b", dut_vec(), RST_VEC);
      end
      m_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         logic [3:0] c;
         logic b;
         c = 4'b0;
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 19) == 0) c[i] = 1'b1;
         b = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 599) == 0) do_reset();
         tick(c, b);
         n_cmp++;
         if (dut_vec() !== m_vec()) begin
            n_bad++; $display("FAIL random k=%0d got=%b exp=%b", k, dut_vec(), m_vec());
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_up_travel();
      test_same_floor();
      test_dir_preserve();
      test_door_hold();
      test_reset_mid_move();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
